memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: Memory_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of stall cycles spent waiting for dmem_ack before the access is aborted (range 1..255).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state updates on the rising edge
  rst  in  1  synchronous reset, active-high
  EX_MEM_CU_signals  in  4  [3] RegWrite, [2] MemtoReg, [1] MemRead, [0] MemWrite
  EX_MEM_ALU_result  in  32  ALU result, also the byte address for memory accesses
  EX_MEM_DMEM_wr_data  in  32  store data
  EX_MEM_wr_addr  in  5  destination register
  dmem_rdata  in  32  read data from data memory, valid when dmem_ack=1
  dmem_ack  in  1  memory completes the current request this cycle
  dmem_req  out  1  access request
  dmem_we  out  1  1 = write, 0 = read
  dmem_addr  out  32  word-aligned byte address
  dmem_wdata  out  32  store data
  Mem_stall  out  1  upstream must hold PC, IF/ID, ID/EX and EX/MEM this cycle
  dmem_err  out  1  sticky error flag: timeout or misaligned access
  MEM_WB_RegWrite  out  1  registered writeback enable
  MEM_WB_rd_field  out  5  registered destination register
  MEM_WB_wr_data  out  32  registered writeback data

Function
REQ-003 A memory operation (mem_op) SHALL be MemRead|MemWrite; if both bits are set, the operation SHALL be treated as a read.
REQ-004 A misaligned operation (mem_op with EX_MEM_ALU_result[1:0]!=0) SHALL NOT assert dmem_req, SHALL set dmem_err, SHALL NOT stall, and SHALL load a bubble into MEM/WB.
REQ-005 dmem_req SHALL be driven combinationally as aligned mem_op && state!=ABORT; dmem_we=MemWrite&&!MemRead; dmem_addr={ALU_result[31:2],2'b00}; dmem_wdata=EX_MEM_DMEM_wr_data.
REQ-006 Mem_stall SHALL equal dmem_req && !dmem_ack && !timeout_hit, so a zero-wait memory (ack in the request cycle) causes no stall.
REQ-007 The FSM SHALL have three states:
  IDLE -> WAIT on dmem_req && !dmem_ack.
  WAIT -> IDLE on dmem_ack.
  WAIT -> ABORT when the wait counter reaches TIMEOUT-1 without ack.
  ABORT -> IDLE unconditionally after 1 cycle.
REQ-008 The wait counter SHALL be 8 bits, SHALL clear in IDLE, SHALL increment each WAIT cycle, and SHALL NOT wrap; timeout_hit = (state==WAIT && cnt==TIMEOUT-1 && !dmem_ack).
REQ-009 On timeout_hit, the stage SHALL set dmem_err, deassert Mem_stall that cycle, and load a bubble into MEM/WB; in ABORT, dmem_req=0 and the stage SHALL NOT stall.
REQ-010 If dmem_ack and timeout_hit coincide, ack SHALL win: the access completes normally and dmem_err is unchanged.
REQ-011 MEM/WB SHALL load every cycle:
  bubble (RegWrite=0, rd=0, data=0) when Mem_stall=1;
  otherwise RegWrite, wr_addr, and data = MemtoReg ? rdata_sel : ALU_result.
REQ-012 rdata_sel SHALL be dmem_rdata when the read completed this cycle, else 0.
REQ-013 Non-memory instructions SHALL pass through with 1-cycle latency; loads SHALL reach MEM/WB 1 cycle after the ack cycle.
REQ-014 dmem_err SHALL stay set until rst.
REQ-015 dmem_ack SHALL be ignored when dmem_req=0.

Reset
REQ-016 With rst=1 at a clock edge, the stage SHALL go to state IDLE with counter=0, dmem_err=0, MEM_WB_RegWrite=0, MEM_WB_rd_field=0 and MEM_WB_wr_data=0.
REQ-017 While rst=1, Mem_stall and dmem_req SHALL be 0.
REQ-018 A reset asserted during WAIT SHALL abandon the access without setting dmem_err.

Structure
REQ-019 The shared package SHALL hold the CU bit indices (REGWRITE=3, MEMTOREG=2, MEMREAD=1, MEMWRITE=0), the FSM state encodings (IDLE=2'd0, WAIT=2'd1, ABORT=2'd2) and the MEM/WB width of 38.
REQ-020 The MEM/WB register SHALL reuse pipeline_register #(38) with Hold_data tied 0; the FSM and counter SHALL be inline logic.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  ALU op RegWrite=1, rd=5, result 0x1234, no mem_op -> next cycle MEM_WB_RegWrite=1, rd=5, data=0x1234, Mem_stall never asserted.
  Load addr 0x40, ack same cycle, rdata 0xCAFEBABE, MemtoReg=1 -> no stall; next cycle MEM_WB_wr_data=0xCAFEBABE.
  Store addr 0x80, data 0xDEADBEEF, ack after 3 cycles -> Mem_stall=1 for exactly 3 cycles, dmem_we=1, MEM/WB holds bubbles during the stall.
  Load with TIMEOUT=4 and no ack -> Mem_stall high for 3 cycles, then dmem_err=1, bubble loaded, ABORT for 1 cycle, then IDLE.
  Load addr 0x42 -> dmem_req=0, dmem_err=1, MEM_WB_RegWrite=0.
  rst pulsed in WAIT cycle 2 -> next cycle state IDLE, dmem_req=0, dmem_err=0, all MEM_WB outputs 0.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: control-word bit positions,
// FSM state encoding and the MEM/WB register layout.
package memory_stage_pkg;

   localparam int REGWRITE = 3;
   localparam int MEMTOREG = 2;
   localparam int MEMREAD  = 1;
   localparam int MEMWRITE = 0;

   localparam int MEMWB_W = 38;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      ABORT = 2'd2
   } state_t;

   // MEM/WB layout, MSB first: {RegWrite, rd[4:0], data[31:0]}
   function automatic logic [MEMWB_W-1:0] pack_memwb(input logic        reg_write,
                                                     input logic [4:0]  rd,
                                                     input logic [31:0] data);
      return {reg_write, rd, data};
   endfunction

endpackage

// File: rtl/pipeline_register.sv
// Generic pipeline register with synchronous reset and a hold (enable-low) input.
module pipeline_register #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Hold_data,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else if (!Hold_data) begin
         data_q <= data_i;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls upstream while waiting
// for ack, aborts on timeout or misalignment, and loads the MEM/WB register.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  EX_MEM_CU_signals,
   input  logic [31:0] EX_MEM_ALU_result,
   input  logic [31:0] EX_MEM_DMEM_wr_data,
   input  logic [4:0]  EX_MEM_wr_addr,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic        Mem_stall,
   output logic        dmem_err,
   output logic        MEM_WB_RegWrite,
   output logic [4:0]  MEM_WB_rd_field,
   output logic [31:0] MEM_WB_wr_data,
   output state_t      dbg_state_o
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                err_q, err_d;

   logic                mem_op;
   logic                misaligned;
   logic                ack_v;
   logic                timeout_hit;
   logic                bubble;
   logic [31:0]         rdata_sel;
   logic [MEMWB_W-1:0]  memwb_d;
   logic [MEMWB_W-1:0]  memwb_q;

   // Request side and stall; a read wins when both MemRead and MemWrite are set.
   always_comb begin
      mem_op      = EX_MEM_CU_signals[MEMREAD] | EX_MEM_CU_signals[MEMWRITE];
      misaligned  = mem_op && (EX_MEM_ALU_result[1:0] != 2'b00);
      dmem_req    = !rst && mem_op && !misaligned && (state_q != ABORT);
      dmem_we     = EX_MEM_CU_signals[MEMWRITE] && !EX_MEM_CU_signals[MEMREAD];
      dmem_addr   = {EX_MEM_ALU_result[31:2], 2'b00};
      dmem_wdata  = EX_MEM_DMEM_wr_data;
      ack_v       = dmem_req && dmem_ack;
      timeout_hit = (state_q == WAIT) && (cnt_q >= TO_LAST) && !ack_v;
      Mem_stall   = dmem_req && !ack_v && !timeout_hit;
   end

   // MEM/WB next value: bubble on stall, misalignment or timeout.
   always_comb begin
      rdata_sel = '0;
      if (ack_v && EX_MEM_CU_signals[MEMREAD]) begin
         rdata_sel = dmem_rdata;
      end
      bubble  = Mem_stall || misaligned || timeout_hit;
      memwb_d = '0;
      if (!bubble) begin
         memwb_d = pack_memwb(EX_MEM_CU_signals[REGWRITE], EX_MEM_wr_addr,
                              EX_MEM_CU_signals[MEMTOREG] ? rdata_sel : EX_MEM_ALU_result);
      end
   end

   // cnt_q holds the number of stall cycles already spent on the current access.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q | timeout_hit | misaligned;
      case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            if (dmem_req && !dmem_ack) begin
               state_d = WAIT;
               cnt_d   = 8'd1;
            end
         end
         WAIT: begin
            if (!dmem_req || ack_v) begin
               state_d = IDLE;
               cnt_d   = 8'd0;
            end else if (timeout_hit) begin
               state_d = ABORT;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ABORT: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   pipeline_register #(.WIDTH(MEMWB_W)) u_mem_wb (
      .clk       (clk),
      .rst       (rst),
      .Hold_data (1'b0),
      .data_i    (memwb_d),
      .data_o    (memwb_q)
   );

   assign {MEM_WB_RegWrite, MEM_WB_rd_field, MEM_WB_wr_data} = memwb_q;
   assign dmem_err    = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios followed by random instructions,
// each checked against a transaction-level model of the stage.
module tb_memory_stage;
   import memory_stage_pkg::*;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  cu;
   logic [31:0] alu;
   logic [31:0] wdata;
   logic [4:0]  rd;
   logic [31:0] rdata;
   logic        ack;
   logic        dmem_req, dmem_we, Mem_stall, dmem_err;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        MEM_WB_RegWrite;
   logic [4:0]  MEM_WB_rd_field;
   logic [31:0] MEM_WB_wr_data;
   state_t      dbg_state;

   int          tests = 0;
   int          fails = 0;
   logic        exp_err;
   logic [37:0] exp_q[$];

   memory_stage #(.TIMEOUT(TIMEOUT)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .EX_MEM_CU_signals   (cu),
      .EX_MEM_ALU_result   (alu),
      .EX_MEM_DMEM_wr_data (wdata),
      .EX_MEM_wr_addr      (rd),
      .dmem_rdata          (rdata),
      .dmem_ack            (ack),
      .dmem_req            (dmem_req),
      .dmem_we             (dmem_we),
      .dmem_addr           (dmem_addr),
      .dmem_wdata          (dmem_wdata),
      .Mem_stall           (Mem_stall),
      .dmem_err            (dmem_err),
      .MEM_WB_RegWrite     (MEM_WB_RegWrite),
      .MEM_WB_rd_field     (MEM_WB_rd_field),
      .MEM_WB_wr_data      (MEM_WB_wr_data),
      .dbg_state_o         (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_memwb(input string tag);
      logic [37:0] exp;
      exp = exp_q.pop_front();
      chk(tag, {MEM_WB_RegWrite, MEM_WB_rd_field, MEM_WB_wr_data}, exp);
   endtask

   task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] r, input logic [31:0] rdat, input logic ak);
      @(negedge clk);
      cu = c; alu = a; wdata = wd; rd = r; rdata = rdat; ack = ak;
   endtask

   // One instruction through MEM; lat = cycles before ack (>= TIMEOUT means never).
   task automatic exec(input logic [3:0] c, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] r, input logic [31:0] rdat, input int lat);
      logic memop, mis, is_rd, tmo;
      int   ncyc;
      memop = c[1] | c[0];
      is_rd = c[1];
      mis   = memop && (a[1:0] != 2'b00);
      if (!memop || mis) begin
         drive(c, a, wd, r, rdat, 1'($urandom_range(0, 1)));
         #1;
         chk("req_nomem", dmem_req, 0);
         chk("stall_nomem", Mem_stall, 0);
         if (mis) begin
            exp_err = 1'b1;
            exp_q.push_back('0);
         end else begin
            exp_q.push_back({c[3], r, c[2] ? 32'h0 : a});
         end
         @(posedge clk); #1;
         chk_memwb("memwb_nomem");
         chk("err_nomem", dmem_err, exp_err);
      end else begin
         tmo  = (lat >= TIMEOUT);
         ncyc = tmo ? TIMEOUT : lat + 1;
         for (int k = 0; k < ncyc; k++) begin
            drive(c, a, wd, r, rdat, !tmo && (k == lat));
            #1;
            chk("req_mem", dmem_req, 1);
            chk("stall_mem", Mem_stall, k < ncyc - 1);
            if (k == 0) begin
               chk("we", dmem_we, c[0] && !c[1]);
               chk("addr", dmem_addr, {a[31:2], 2'b00});
               chk("wdata", dmem_wdata, wd);
            end
            if (k < ncyc - 1) exp_q.push_back('0);
            else if (tmo) exp_q.push_back('0);
            else exp_q.push_back({c[3], r, c[2] ? (is_rd ? rdat : 32'h0) : a});
            @(posedge clk); #1;
            chk_memwb("memwb_mem");
         end
         if (tmo) begin
            exp_err = 1'b1;
            chk("err_tmo", dmem_err, 1);
            chk("state_abort", dbg_state, ABORT);
            // ABORT cycle: request suppressed, stray ack must be ignored.
            drive(c, a, wd, r, rdat, 1'b1);
            #1;
            chk("req_abort", dmem_req, 0);
            chk("stall_abort", Mem_stall, 0);
            exp_q.push_back({c[3], r, c[2] ? 32'h0 : a});
            @(posedge clk); #1;
            chk_memwb("memwb_abort");
            chk("state_idle", dbg_state, IDLE);
         end
         chk("err_mem", dmem_err, exp_err);
      end
   endtask

   initial begin
      rst = 1'b1; exp_err = 1'b0;
      cu = 4'b0110; alu = 32'h40; wdata = '0; rd = 5'd1; rdata = '0; ack = 1'b0;
      #1;
      chk("req_in_rst", dmem_req, 0);
      chk("stall_in_rst", Mem_stall, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", dbg_state, IDLE);
      chk("rst_err", dmem_err, 0);
      chk("rst_memwb", {MEM_WB_RegWrite, MEM_WB_rd_field, MEM_WB_wr_data}, 0);
      @(negedge clk);
      rst = 1'b0;

      exec(4'b1000, 32'h1234, 32'h0, 5'd5, 32'h0, 0);
      exec(4'b1110, 32'h40, 32'h0, 5'd7, 32'hCAFEBABE, 0);
      exec(4'b0001, 32'h80, 32'hDEADBEEF, 5'd0, 32'h0, 3);
      exec(4'b1110, 32'hC0, 32'h0, 5'd9, 32'h11112222, 99);
      exec(4'b1110, 32'h42, 32'h0, 5'd3, 32'h0, 0);

      // Reset in the second WAIT cycle abandons the access and clears the error.
      drive(4'b1110, 32'h100, 32'h0, 5'd4, 32'h0, 1'b0);
      @(posedge clk);
      drive(4'b1110, 32'h100, 32'h0, 5'd4, 32'h0, 1'b0);
      #1;
      chk("stall_wait1", Mem_stall, 1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("req_rst_wait", dmem_req, 0);
      chk("stall_rst_wait", Mem_stall, 0);
      @(posedge clk); #1;
      chk("rst_wait_state", dbg_state, IDLE);
      chk("rst_wait_err", dmem_err, 0);
      chk("rst_wait_memwb", {MEM_WB_RegWrite, MEM_WB_rd_field, MEM_WB_wr_data}, 0);
      drive(4'b0000, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
      rst = 1'b0;
      exp_err = 1'b0;
      #1;
      chk("req_after_rst", dmem_req, 0);

      for (int i = 0; i < 80; i++) begin
         logic [31:0] a;
         a = $urandom;
         if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
         exec(4'($urandom_range(0, 15)), a, $urandom, 5'($urandom_range(0, 31)),
              $urandom, $urandom_range(0, 5));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
